// File: rtl/linear_m_inv_serial.sv
// linear_m_inv_serial: serial inverse PRINCE linear layer, y = M'(SR^-1(x)), one 16-bit column per cycle.
module linear_m_inv_serial (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] data_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] data_out
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t      state, state_nxt;
   logic [1:0]  cnt;
   logic [63:0] work, res, sr;
   logic [15:0] col;

   // Output nibble r, bit p (p=0 is MSB) drops the input row k where (r+k+off)%4 == p.
   function automatic logic [15:0] mhat(input logic [15:0] c, input logic off);
      logic [15:0] y;
      y = '0;
      for (int r = 0; r < 4; r++)
         for (int p = 0; p < 4; p++)
            for (int k = 0; k < 4; k++)
               if (((r + k + int'(off)) % 4) != p)
                  y[15-4*r-p] = y[15-4*r-p] ^ c[15-4*k-p];
      return y;
   endfunction

   assign sr = {data_in[63:60], data_in[11:8],  data_in[23:20], data_in[35:32],
                data_in[47:44], data_in[59:56], data_in[7:4],   data_in[19:16],
                data_in[31:28], data_in[43:40], data_in[55:52], data_in[3:0],
                data_in[15:12], data_in[27:24], data_in[39:36], data_in[51:48]};

   // Counter 0..3 walks col3..col0; middle columns use the off=1 matrix.
   assign col       = mhat(work[{~cnt, 4'b0} +: 16], cnt[1] ^ cnt[0]);
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign data_out  = res;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE && in_valid)   ? CALC :
                  (state == CALC && cnt == 2'd3) ? DONE :
                  (state == DONE && out_ready)  ? IDLE : state;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt  <= '0;
         work <= '0;
         res  <= '0;
      end else if (state == IDLE && in_valid) begin
         work <= sr;
         cnt  <= '0;
      end else if (state == CALC) begin
         res[{~cnt, 4'b0} +: 16] <= col;
         cnt                     <= cnt + 2'd1;
      end
endmodule

// File: tb/tb_linear_m_inv_serial.sv
// tb_linear_m_inv_serial: randomized and directed checks of linear_m_inv_serial against a nibble-level model.
module tb_linear_m_inv_serial;
   logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
   logic [63:0] data_in = '0;
   logic        in_ready, out_valid;
   logic [63:0] data_out;
   int          checks = 0, failures = 0;
   int          src[16] = '{12, 9, 6, 3, 0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15};

   linear_m_inv_serial dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] sr_inv(input logic [63:0] x);
      logic [63:0] s;
      for (int n = 0; n < 16; n++) s[4*n +: 4] = x[4*src[n] +: 4];
      return s;
   endfunction

   function automatic logic [63:0] sr_fwd(input logic [63:0] t);
      logic [63:0] r;
      for (int n = 0; n < 16; n++) r[4*src[n] +: 4] = t[4*n +: 4];
      return r;
   endfunction

   // Each output bit is the column parity at that bit position minus the one excluded row.
   function automatic logic [63:0] mprime(input logic [63:0] v);
      logic [63:0] o;
      logic [3:0]  row[4];
      logic [3:0]  tot;
      int          off, kx;
      for (int c = 0; c < 4; c++) begin
         off = (c == 1 || c == 2) ? 1 : 0;
         tot = '0;
         for (int k = 0; k < 4; k++) begin
            row[k] = v[16*c+12-4*k +: 4];
            tot    = tot ^ row[k];
         end
         for (int r = 0; r < 4; r++)
            for (int p = 0; p < 4; p++) begin
               kx = (p - r - off + 8) % 4;
               o[16*c+12-4*r+3-p] = tot[3-p] ^ row[kx][3-p];
            end
      end
      return o;
   endfunction

   function automatic logic [63:0] ref_y(input logic [63:0] x);
      return mprime(sr_inv(x));
   endfunction

   function automatic logic [63:0] lin_m(input logic [63:0] y);
      return sr_fwd(mprime(y));
   endfunction

   task automatic send(input logic [63:0] x, output logic [63:0] y, output int lat);
      int n;
      in_valid = 1;
      data_in  = x;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) check("in_ready_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 50) check("out_valid_timeout", 64'(out_valid), 64'd1);
      y = data_out;
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
   endtask

   initial begin
      logic [63:0] x, y, ya, yb, yab, y0;
      logic [63:0] w[8];
      int lat, ni, no, cyc;
      logic hs_in, hs_out;
      logic [63:0] got;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_data_out", data_out, 64'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      send(64'h0, y, lat);
      check("zero_y", y, 64'h0);
      check("zero_lat", 64'(lat), 64'd4);
      send('1, y, lat);
      check("ones_y", y, '1);
      check("ones_lat", 64'(lat), 64'd4);
      check("idle_after_out", 64'(in_ready), 64'd1);

      // Reset while two columns are already computed.
      in_valid = 1;
      data_in  = 64'h1234_5678_9ABC_DEF0;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 0;
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_data_out", data_out, 64'h0);
      @(posedge clk); #1 rst_n = 1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("midrst_no_pulse", 64'(out_valid), 64'd0);
      end
      x = 64'hDEAD_BEEF_0BAD_F00D;
      send(x, y, lat);
      check("after_rst_y", y, ref_y(x));
      check("after_rst_lat", 64'(lat), 64'd4);

      send(64'h0123_4567_89AB_CDEF, ya, lat);
      send(64'hFEDC_BA98_7654_3210, yb, lat);
      send(64'h0123_4567_89AB_CDEF ^ 64'hFEDC_BA98_7654_3210, yab, lat);
      check("linearity", ya ^ yb, yab);
      check("lin_model_a", ya, ref_y(64'h0123_4567_89AB_CDEF));

      // Output backpressure with ignored input pulses.
      x = {$urandom, $urandom};
      in_valid = 1;
      data_in  = x;
      @(posedge clk); #1;
      in_valid = 0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp_lat", 64'(lat), 64'd4);
      y0 = data_out;
      check("bp_y", y0, ref_y(x));
      for (int i = 0; i < 7; i++) begin
         in_valid = i[0];
         data_in  = {$urandom, $urandom};
         @(posedge clk); #1;
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_stable", data_out, y0);
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 0;
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      check("bp_release_out_valid", 64'(out_valid), 64'd0);
      repeat (3) @(posedge clk);
      #1 check("bp_no_ghost", 64'(out_valid), 64'd0);

      // Back-to-back stream.
      for (int i = 0; i < 8; i++) w[i] = {$urandom, $urandom};
      ni = 0;
      no = 0;
      cyc = 0;
      data_in   = w[0];
      in_valid  = 1;
      out_ready = 1;
      while (no < 8 && cyc < 200) begin
         hs_in  = in_valid && in_ready;
         hs_out = out_valid && out_ready;
         got    = data_out;
         @(posedge clk); #1;
         cyc++;
         if (hs_out) begin
            check("stream_y", got, ref_y(w[no]));
            no++;
         end
         if (hs_in) begin
            ni++;
            if (ni < 8) data_in = w[ni];
            else in_valid = 0;
         end
      end
      check("stream_count", 64'(no), 64'd8);
      check("stream_accepted", 64'(ni), 64'd8);
      repeat (8) @(posedge clk);
      #1 check("stream_no_dup", 64'(out_valid), 64'd0);
      out_ready = 0;

      for (int i = 0; i < 10000; i++) begin
         x = {$urandom, $urandom};
         send(x, y, lat);
         check("rand_model", y, ref_y(x));
         check("rand_roundtrip", lin_m(y), x);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
